prog_freq_gen: RTL and testbench

//  Multi-channel programmable square-wave/tick generator for the PWM carrier path.

---
 rtl/prog_freq_gen_if.sv | 26 ++
 rtl/prog_freq_gen.sv | 96 +++++++++
 tb/tb_prog_freq_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_freq_gen_if.sv
// Control/status bundle for the multi-channel square-wave generator.
// Master drives enables, sync and half-period writes; slave returns waves, ticks and pending flags.
interface prog_freq_gen_if #(
  parameter int NCH = 4,
  parameter int CW  = 10,
  parameter int CHW = 2
);
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0]  wr_half;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  modport master (
    output en, sync, wr_en, wr_ch, wr_half,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_half,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/prog_freq_gen.sv
// Multi-channel programmable divider: each channel toggles clk_out every (active+1) enabled cycles.
// Outputs are registered (1 cycle after the deciding edge); no backpressure, writes always accepted.
module prog_freq_gen #(
  parameter int NCH      = 4,
  parameter int CW       = 10,
  parameter int CHW      = 2,
  parameter int DEF_HALF = 999
) (
  input  logic           clk,
  input  logic           rst,
  prog_freq_gen_if.slave bus
);

  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [CW-1:0]  active_q [NCH];
  logic [CW-1:0]  active_d [NCH];
  logic [CW-1:0]  shadow_q [NCH];
  logic [CW-1:0]  shadow_d [NCH];
  logic [NCH-1:0] clk_out_q, clk_out_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] pending_q, pending_d;

  logic [NCH-1:0] restart;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] wr_hit;

  always_comb begin
    restart = {NCH{bus.sync}} | ~bus.en;
    wrap    = '0;
    wr_hit  = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i]   = (cnt_q[i] >= active_q[i]);
      // Channel numbers beyond NCH never match, so such writes fall on the floor.
      wr_hit[i] = bus.wr_en && (bus.wr_ch == CHW'(i));
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    clk_out_d = clk_out_q;
    tick_d    = '0;
    pending_d = pending_q;
    for (int i = 0; i < NCH; i++) begin
      if (restart[i]) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
      end else if (wrap[i]) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = ~clk_out_q[i];
        tick_d[i]    = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end

      // Apply reads the old shadow; a same-cycle write re-arms pending for the next boundary.
      if ((restart[i] || wrap[i]) && pending_q[i]) begin
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      if (wr_hit[i]) begin
        shadow_d[i]  = bus.wr_half;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= '0;
        active_q[i] <= CW'(DEF_HALF);
        shadow_q[i] <= CW'(DEF_HALF);
      end
      clk_out_q <= '0;
      tick_q    <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_prog_freq_gen.sv
// Bench for prog_freq_gen: directed scenarios plus a randomized run against a countdown-based model.
module tb_prog_freq_gen;
  localparam int NCH      = 4;
  localparam int CW       = 10;
  localparam int CHW      = 3;
  localparam int DEF_HALF = 999;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  prog_freq_gen_if #(.NCH(NCH), .CW(CW), .CHW(CHW)) bus ();

  prog_freq_gen #(.NCH(NCH), .CW(CW), .CHW(CHW), .DEF_HALF(DEF_HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each channel counts down the enabled cycles left until its next edge.
  int             m_active [NCH];
  int             m_shadow [NCH];
  int             m_rem    [NCH];
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_pend;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_active[c] = DEF_HALF;
      m_shadow[c] = DEF_HALF;
      m_rem[c]    = DEF_HALF + 1;
    end
    m_clk  = '0;
    m_tick = '0;
    m_pend = '0;
  endtask

  task automatic model_step();
    bit edge_now;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      edge_now = 1'b0;
      m_tick[c] = 1'b0;
      if (bus.sync || !bus.en[c]) begin
        m_clk[c] = 1'b0;
        edge_now = 1'b1;
      end else begin
        m_rem[c] = m_rem[c] - 1;
        if (m_rem[c] == 0) begin
          m_clk[c]  = ~m_clk[c];
          m_tick[c] = 1'b1;
          edge_now  = 1'b1;
        end
      end
      if (edge_now) begin
        if (m_pend[c]) begin
          m_active[c] = m_shadow[c];
          m_pend[c]   = 1'b0;
        end
        m_rem[c] = m_active[c] + 1;
      end
      if (bus.wr_en && int'(bus.wr_ch) == c) begin
        m_shadow[c] = int'(bus.wr_half);
        m_pend[c]   = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_write(input int ch, input int half);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = CHW'(ch);
    bus.wr_half = CW'(half);
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  // Returns cycles until tick[ch] is seen, or -1 once the budget runs out.
  task automatic run_until_tick(input int ch, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      cyc();
      if (bus.tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if (bus.clk_out !== '0 || bus.tick !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: clk_out=%b tick=%b, required 0000 0000", bus.clk_out, bus.tick);
    end
    n_checks++;
    if (bus.pending !== '0) begin
      n_fail++;
      $display("FAIL reset_pending: got %b, required 0000", bus.pending);
    end
    rst = 1'b0;
    cyc();
    n_checks++;
    if ({bus.clk_out, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, required %b", {bus.clk_out, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
    end
  endtask

  task automatic test_default_period();
    int n;
    bus.en = 4'b0001;
    run_until_tick(0, 1500, n);
    n_checks++;
    if (n !== 1000) begin
      n_fail++;
      $display("FAIL default_first_half: got %0d cycles, required 1000", n);
    end
    run_until_tick(0, 1500, n);
    n_checks++;
    if (n !== 1000) begin
      n_fail++;
      $display("FAIL default_second_half: got %0d cycles, required 1000", n);
    end
    n_checks++;
    if (bus.clk_out !== 4'b0000 || bus.tick !== 4'b0001) begin
      n_fail++;
      $display("FAIL default_other_channels: clk_out=%b tick=%b, required 0000 0001", bus.clk_out, bus.tick);
    end
  endtask

  task automatic test_reload();
    int n;
    repeat (300) cyc();
    do_write(0, 4);
    n_checks++;
    if (bus.pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_pending_set: got %b, required 1", bus.pending[0]);
    end
    run_until_tick(0, 1500, n);
    n_checks++;
    if (n !== 699) begin
      n_fail++;
      $display("FAIL reload_old_half_completes: got %0d cycles, required 699", n);
    end
    n_checks++;
    if (bus.pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_pending_clear: got %b, required 0", bus.pending[0]);
    end
    for (int h = 0; h < 2; h++) begin
      run_until_tick(0, 20, n);
      n_checks++;
      if (n !== 5) begin
        n_fail++;
        $display("FAIL reload_new_half%0d: got %0d cycles, required 5", h, n);
      end
    end
  endtask

  task automatic test_write_on_wrap();
    int n;
    bus.en = 4'b0000;
    do_write(1, 9);
    cyc();
    bus.en = 4'b0010;
    for (int k = 0; k < 20 && m_rem[1] != 1; k++) cyc();
    do_write(1, 3);
    n_checks++;
    if (bus.tick[1] !== 1'b1 || bus.pending[1] !== 1'b1 || bus.clk_out[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_write_edge: tick=%b pending=%b clk_out=%b, required 1 1 1", bus.tick[1], bus.pending[1], bus.clk_out[1]);
    end
    run_until_tick(1, 30, n);
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL wrap_write_old_half: got %0d cycles, required 10", n);
    end
    for (int h = 0; h < 2; h++) begin
      run_until_tick(1, 30, n);
      n_checks++;
      if (n !== 4) begin
        n_fail++;
        $display("FAIL wrap_write_new_half%0d: got %0d cycles, required 4", h, n);
      end
    end
  endtask

  task automatic test_sync_and_bad_ch();
    int t2, t3;
    bus.en = 4'b0000;
    do_write(2, 2);
    do_write(3, 5);
    cyc();
    bus.en = 4'b1100;
    repeat ($urandom_range(3, 12)) cyc();
    bus.sync = 1'b1;
    cyc();
    bus.sync = 1'b0;
    n_checks++;
    if (bus.clk_out[3:2] !== 2'b00 || bus.tick[3:2] !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_clears: clk_out=%b tick=%b, required 00 00", bus.clk_out[3:2], bus.tick[3:2]);
    end
    t2 = -1;
    t3 = -1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (bus.tick[2] && t2 < 0) t2 = k;
      if (bus.tick[3] && t3 < 0) t3 = k;
    end
    n_checks++;
    if (t2 !== 3 || t3 !== 6) begin
      n_fail++;
      $display("FAIL sync_first_toggle: ch2=%0d ch3=%0d, required 3 6", t2, t3);
    end
    do_write(5, 1);
    do_write(4, 0);
    n_checks++;
    if (bus.pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL bad_channel_write: pending=%b, required 0000", bus.pending);
    end
    for (int k = 0; k < 24; k++) begin
      cyc();
      n_checks++;
      if ({bus.clk_out, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
        n_fail++;
        $display("FAIL bad_channel_run cyc%0d: got %b, required %b", k, {bus.clk_out, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
    end
  endtask

  task automatic test_half_zero();
    bus.en = 4'b0000;
    do_write(0, 0);
    cyc();
    bus.en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_checks++;
      if (bus.tick[0] !== 1'b1 || bus.clk_out[0] !== 1'(k % 2)) begin
        n_fail++;
        $display("FAIL half_zero cyc%0d: tick=%b clk_out=%b, required 1 %0d", k, bus.tick[0], bus.clk_out[0], k % 2);
      end
    end
    bus.en = 4'b0000;
    cyc();
    n_checks++;
    if (bus.clk_out[0] !== 1'b0 || bus.tick[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL half_zero_disable: clk_out=%b tick=%b, required 0 0", bus.clk_out[0], bus.tick[0]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bus.en = 4'b0001;
    do_write(0, 7);
    n_checks++;
    if (bus.pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_setup_pending: got %b, required 1", bus.pending[0]);
    end
    cyc();
    for (int k = 0; k < 40 && !(m_clk[0] && m_rem[0] >= 3); k++) cyc();
    do_write(0, 3);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.clk_out !== '0 || bus.tick !== '0 || bus.pending !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: clk_out=%b tick=%b pending=%b, required all 0", bus.clk_out, bus.tick, bus.pending);
    end
    cyc();
    cyc();
    rst = 1'b0;
    run_until_tick(0, 1500, n);
    n_checks++;
    if (n !== 1000) begin
      n_fail++;
      $display("FAIL arst_first_half: got %0d cycles, required 1000", n);
    end
    run_until_tick(0, 1500, n);
    n_checks++;
    if (n !== 1000 || bus.pending !== '0) begin
      n_fail++;
      $display("FAIL arst_second_half: got %0d cycles pending=%b, required 1000 0000", n, bus.pending);
    end
  endtask

  task automatic test_random();
    bus.en = 4'($urandom_range(0, 15));
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 31) == 0) bus.en = 4'($urandom_range(0, 15));
      bus.sync    = ($urandom_range(0, 63) == 0);
      bus.wr_en   = ($urandom_range(0, 5) == 0);
      bus.wr_ch   = CHW'($urandom_range(0, 7));
      bus.wr_half = CW'($urandom_range(0, 12));
      cyc();
      n_checks++;
      if ({bus.clk_out, bus.tick, bus.pending} !== {m_clk, m_tick, m_pend}) begin
        n_fail++;
        $display("FAIL random cyc%0d: got clk/tick/pend %b, required %b", k, {bus.clk_out, bus.tick, bus.pending}, {m_clk, m_tick, m_pend});
      end
    end
    bus.sync  = 1'b0;
    bus.wr_en = 1'b0;
    bus.en    = '0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.en      = '0;
    bus.sync    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_half = '0;
    model_reset();
    test_reset();
    test_default_period();
    test_reload();
    test_write_on_wrap();
    test_sync_and_bad_ch();
    test_half_zero();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
